// File: rtl/tftp_data_encode_pkg.sv
// Shared constants, state encoding and header helper for the TFTP DATA encoder.
package tftp_data_encode_pkg;

    // TFTP opcodes
    localparam logic [15:0] OP_RRQ   = 16'd1;
    localparam logic [15:0] OP_WRQ   = 16'd2;
    localparam logic [15:0] OP_DATA  = 16'd3;
    localparam logic [15:0] OP_ACK   = 16'd4;
    localparam logic [15:0] OP_ERROR = 16'd5;

    // Default maximum payload bytes per DATA packet
    localparam int BLOCK_LEN_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

    // Header byte idx of a DATA packet: opcode then block number, both big-endian.
    function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                            input logic [15:0] opcode,
                                            input logic [15:0] block);
        logic [7:0] b;
        case (idx)
            2'd0:    b = opcode[15:8];
            2'd1:    b = opcode[7:0];
            2'd2:    b = block[15:8];
            default: b = block[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tftp_data_encode_if.sv
// Byte-stream and file-memory bus between the DATA encoder and its neighbours.
interface tftp_data_encode_if #(
    parameter int MEM_AW = 16
);
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;

    modport master (
        output tx_data, tx_valid, tx_last, mem_addr, mem_rd,
        input  tx_ready, mem_data
    );

    modport slave (
        input  tx_data, tx_valid, tx_last, mem_addr, mem_rd,
        output tx_ready, mem_data
    );
endinterface

// File: rtl/tftp_data_encode_rd_prefetch.sv
// Two-entry prefetch buffer: issues file-memory reads ahead of the byte stream
// so the 1-cycle read latency never shows up as a bubble on the output.
module tftp_data_encode_rd_prefetch #(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic [9:0]        rd_len,
    input  logic              pop,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [7:0]        head_data,
    output logic              head_valid
);

    logic [MEM_AW-1:0] addr_q;
    logic [9:0]        rd_left;
    logic              inflight;
    logic [7:0]        buf_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        occ;

    // Occupancy counts the read in flight, so a slot is reserved before data lands.
    always_comb begin
        occ        = count + {1'b0, inflight};
        mem_rd     = (rd_left != 10'd0) && ((occ < 2'd2) || pop);
        mem_addr   = addr_q;
        head_valid = (count != 2'd0);
        head_data  = buf_q[rd_ptr];
    end

    // Read issue, capture of returning data and buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            rd_left  <= '0;
            inflight <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else if (load) begin
            addr_q   <= base_addr;
            rd_left  <= rd_len;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= mem_rd;
            if (mem_rd) begin
                addr_q  <= addr_q + 1'b1;
                rd_left <= rd_left - 10'd1;
            end
            if (inflight) begin
                buf_q[wr_ptr] <= mem_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tftp_data_encode.sv
// TFTP DATA packet serializer: emits opcode, block number and the file bytes
// of one block as a ready/valid byte stream.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for start; inputs latched when start seen
//  HDR     | sending 4 header bytes; prefetch of file data under way
//  DATA    | sending data_len file bytes from the prefetch buffer
//  DONE    | one cycle with done=1, then back to IDLE
module tftp_data_encode
    import tftp_data_encode_pkg::*;
#(
    parameter int          BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int          MEM_AW    = 16,
    parameter logic [15:0] OPCODE    = OP_DATA
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         block_num,
    input  logic [MEM_AW-1:0]   mem_location,
    input  logic [15:0]         file_len,
    tftp_data_encode_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic [9:0]          data_len
);

    localparam int LOG2_BL = $clog2(BLOCK_LEN);
    localparam int OFF_W   = 16 + LOG2_BL;

    enc_state_t        state, state_nx;
    logic [1:0]        hdr_idx;
    logic [9:0]        byte_cnt;
    logic [15:0]       bn_q;

    logic              start_ok;
    logic [OFF_W-1:0]  offset_calc;
    logic [OFF_W-1:0]  flen_ext;
    logic [OFF_W-1:0]  rem_calc;
    logic [9:0]        dlen_calc;
    logic [MEM_AW-1:0] base_calc;

    logic [7:0]        tx_data_c;
    logic              tx_valid_c;
    logic              tx_last_c;
    logic              xfer;
    logic              pop;
    logic [7:0]        head_data;
    logic              head_valid;

    assign start_ok = (state == ST_IDLE) && start;

    // Block offset and payload length; offset is kept wide so large block
    // numbers never alias back into the file.
    always_comb begin
        offset_calc = OFF_W'(block_num - 16'd1) << LOG2_BL;
        flen_ext    = OFF_W'(file_len);
        rem_calc    = flen_ext - offset_calc;
        if ((block_num == 16'd0) || (offset_calc >= flen_ext))
            dlen_calc = 10'd0;
        else if (rem_calc > OFF_W'(BLOCK_LEN))
            dlen_calc = 10'(BLOCK_LEN);
        else
            dlen_calc = rem_calc[9:0];
        base_calc = mem_location + MEM_AW'(offset_calc);
    end

    // State register plus header/data byte counters and latched packet info.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            hdr_idx  <= '0;
            byte_cnt <= '0;
            bn_q     <= '0;
            data_len <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                bn_q     <= block_num;
                data_len <= dlen_calc;
                hdr_idx  <= '0;
                byte_cnt <= '0;
            end else if (xfer) begin
                if (state == ST_HDR)
                    hdr_idx <= hdr_idx + 2'd1;
                if (state == ST_DATA)
                    byte_cnt <= byte_cnt + 10'd1;
            end
        end
    end

    // Next state and stream outputs; the stream only advances on a transfer.
    always_comb begin
        state_nx   = state;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        tx_last_c  = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = ST_HDR;
            end
            ST_HDR: begin
                tx_valid_c = 1'b1;
                tx_data_c  = hdr_byte(hdr_idx, OPCODE, bn_q);
                tx_last_c  = (hdr_idx == 2'd3) && (data_len == 10'd0);
                if (bus.tx_ready && (hdr_idx == 2'd3))
                    state_nx = (data_len == 10'd0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: begin
                tx_valid_c = head_valid;
                tx_data_c  = head_data;
                tx_last_c  = (byte_cnt == data_len - 10'd1);
                pop        = head_valid && bus.tx_ready;
                if (pop && tx_last_c)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign xfer         = tx_valid_c && bus.tx_ready;
    assign busy         = (state != ST_IDLE);
    assign bus.tx_data  = tx_data_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.tx_last  = tx_last_c;

    tftp_data_encode_rd_prefetch #(
        .MEM_AW (MEM_AW)
    ) u_prefetch (
        .clk        (clk),
        .reset      (reset),
        .load       (start_ok),
        .base_addr  (base_calc),
        .rd_len     (dlen_calc),
        .pop        (pop),
        .mem_addr   (bus.mem_addr),
        .mem_rd     (bus.mem_rd),
        .mem_data   (bus.mem_data),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

endmodule

// File: tb/tb_tftp_data_encode.sv
// Directed bench for the TFTP DATA encoder: vector table of packets plus
// hand-written sequences for stalls, ignored starts and mid-packet reset.
module tb_tftp_data_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] block_num;
    logic [15:0] mem_location;
    logic [15:0] file_len;
    logic        busy;
    logic        done;
    logic [9:0]  data_len;

    always #5 clk = ~clk;

    tftp_data_encode_if #(.MEM_AW(16)) bus();

    tftp_data_encode #(
        .BLOCK_LEN (512),
        .MEM_AW    (16),
        .OPCODE    (16'h0003)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .block_num    (block_num),
        .mem_location (mem_location),
        .file_len     (file_len),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .data_len     (data_len)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rand_rdy = 1'b0;

    logic [7:0]  got_d[$];
    bit          got_l[$];
    logic [15:0] rd_q[$];
    int          last_cyc = -1;
    int          stall_cnt = 0;
    int          stall_err = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_d;
    logic        prev_l;

    typedef struct {
        logic [15:0] bn;
        logic [15:0] loc;
        logic [15:0] flen;
        bit          rnd;
        bit          poke;
        int          exp_len;
        logic [15:0] exp_base;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // File memory model: data one cycle after the read strobe; read log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_rd) begin
            bus.mem_data <= mem_byte(bus.mem_addr);
            if (!reset)
                rd_q.push_back(bus.mem_addr);
        end
    end

    // Downstream sink: picks tx_ready for the coming edge, logs transfers,
    // and checks that a stalled byte is held unchanged.
    always @(negedge clk) begin
        bus.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                if (!bus.tx_valid || bus.tx_data !== prev_d || bus.tx_last !== prev_l)
                    stall_err++;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_d     = bus.tx_data;
            prev_l     = bus.tx_last;
            if (bus.tx_valid && bus.tx_ready) begin
                got_d.push_back(bus.tx_data);
                got_l.push_back(bus.tx_last);
                if (bus.tx_last)
                    last_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_packet(input vec_t v);
        int          cnt;
        int          errs;
        int          nexp;
        logic [31:0] hdr;
        logic [7:0]  e;
        got_d.delete();
        got_l.delete();
        rd_q.delete();
        last_cyc = -1;
        rand_rdy = v.rnd;
        hdr      = {16'h0003, v.bn};
        nexp     = 4 + v.exp_len;

        @(negedge clk);
        block_num    = v.bn;
        mem_location = v.loc;
        file_len     = v.flen;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("data_len", data_len, v.exp_len);

        cnt = 0;
        while (!done && cnt < 5000) begin
            if (v.poke && cnt == 6) begin
                start     = 1'b1;
                block_num = 16'd7;
            end else if (v.poke && cnt == 7) begin
                start     = 1'b0;
                block_num = v.bn;
            end
            @(negedge clk);
            cnt++;
        end
        check("done_seen", (cnt < 5000), 1);
        check("done_after_last", cyc - last_cyc, 1);
        if (!v.rnd)
            check("throughput_cycles", cnt, nexp);

        if (v.poke) begin
            start     = 1'b1;
            block_num = 16'd9;
        end
        @(negedge clk);
        start     = 1'b0;
        block_num = v.bn;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);

        check("byte_count", got_d.size(), nexp);
        errs = 0;
        for (int i = 0; i < got_d.size() && i < nexp; i++) begin
            if (i < 4)
                e = hdr[31 - 8*i -: 8];
            else
                e = mem_byte(16'(v.exp_base + 16'(i - 4)));
            if (got_d[i] !== e)
                errs++;
            if (got_l[i] != (i == nexp - 1))
                errs++;
        end
        check("payload_errors", errs, 0);

        check("read_count", rd_q.size(), v.exp_len);
        errs = 0;
        for (int i = 0; i < rd_q.size(); i++)
            if (rd_q[i] !== 16'(v.exp_base + 16'(i)))
                errs++;
        check("read_addr_errors", errs, 0);
    endtask

    // Abort a packet with reset while data byte 10 is on the bus.
    task automatic reset_mid_packet();
        rand_rdy = 1'b0;
        @(negedge clk);
        block_num    = 16'd1;
        mem_location = 16'h0400;
        file_len     = 16'd20;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_valid_byte10", bus.tx_valid, 1);
        check("mid_data_byte10", bus.tx_data, mem_byte(16'h040A));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx_valid", bus.tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
    endtask

    initial begin
        vecs[0]  = '{16'd1,     16'h0400, 16'd20,    1'b0, 1'b0, 20,  16'h0400};
        vecs[1]  = '{16'd2,     16'h0400, 16'd1024,  1'b0, 1'b0, 512, 16'h0600};
        vecs[2]  = '{16'd3,     16'h0400, 16'd1024,  1'b0, 1'b0, 0,   16'h0000};
        vecs[3]  = '{16'd1,     16'h0400, 16'd20,    1'b1, 1'b0, 20,  16'h0400};
        vecs[4]  = '{16'd1,     16'h0400, 16'd20,    1'b0, 1'b1, 20,  16'h0400};
        vecs[5]  = '{16'd1,     16'hFFF0, 16'd32,    1'b0, 1'b0, 32,  16'hFFF0};
        vecs[6]  = '{16'd0,     16'h0400, 16'd100,   1'b0, 1'b0, 0,   16'h0000};
        vecs[7]  = '{16'd3,     16'h1000, 16'd1100,  1'b0, 1'b0, 76,  16'h1400};
        vecs[8]  = '{16'd2,     16'h2000, 16'd600,   1'b1, 1'b0, 88,  16'h2200};
        vecs[9]  = '{16'd1,     16'h3000, 16'd0,     1'b0, 1'b0, 0,   16'h0000};
        vecs[10] = '{16'hFFFF,  16'h0000, 16'hFFFF,  1'b0, 1'b0, 0,   16'h0000};
        vecs[11] = '{16'd1,     16'h3000, 16'd512,   1'b1, 1'b0, 512, 16'h3000};
        vecs[12] = '{16'd128,   16'h0000, 16'hFFFF,  1'b0, 1'b0, 511, 16'hFE00};

        reset        = 1'b1;
        start        = 1'b0;
        block_num    = '0;
        mem_location = '0;
        file_len     = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_last", bus.tx_last, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_len", data_len, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_packet(vecs[i]);

        check("stall_hold_errors", stall_err, 0);
        check("stalls_seen", (stall_cnt > 0), 1);

        reset_mid_packet();
        run_packet(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
